mul_div_unit: RTL and testbench

//   Iterative 32-bit multiply/divide unit directly downstream of the register file.

---
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit that writes its results into the HI/LO registers.
// It takes one shift-add or restoring-subtract step per cycle, then one sign-fix cycle.
module mul_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   logic [1:0]      state_q;
   logic [CW-1:0]   cnt_q;
   logic            is_div_q;
   logic            res_neg_q;
   logic            rem_neg_q;
   logic [XLEN-1:0] mcand_q;
   logic [XLEN-1:0] acc_q;
   logic [XLEN-1:0] mplier_q;
   logic [XLEN-1:0] rs_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic            done_q;
   logic            dz_q;

   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_diff;
   logic [XLEN-1:0] acc_step;
   logic [XLEN-1:0] mplier_step;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;
   logic            divisor_zero;

   always_comb begin
      a_neg = op[0] & rs_data[XLEN-1];
      b_neg = op[0] & rt_data[XLEN-1];
      a_mag = a_neg ? (~rs_data + 1'b1) : rs_data;
      b_mag = b_neg ? (~rt_data + 1'b1) : rt_data;
   end

   // Multiply: {acc, mplier} shifts right; divide: {acc, mplier} shifts left with
   // the partial remainder in acc and quotient bits entering mplier from the right.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      div_shift = {acc_q, mplier_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, mcand_q};
      div_diff  = div_shift[XLEN-1:0] - mcand_q;
      if (is_div_q) begin
         acc_step    = div_ge ? div_diff : div_shift[XLEN-1:0];
         mplier_step = {mplier_q[XLEN-2:0], div_ge};
      end else begin
         acc_step    = mul_sum[XLEN:1];
         mplier_step = {mul_sum[0], mplier_q[XLEN-1:1]};
      end
   end

   always_comb begin
      prod         = {acc_q, mplier_q};
      prod_fix     = res_neg_q ? (~prod + 1'b1) : prod;
      quo_fix      = res_neg_q ? (~mplier_q + 1'b1) : mplier_q;
      rem_fix      = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
      divisor_zero = (mcand_q == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         rs_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  is_div_q  <= op[1];
                  res_neg_q <= a_neg ^ b_neg;
                  rem_neg_q <= op[1] & a_neg;
                  mcand_q   <= b_mag;
                  acc_q     <= '0;
                  mplier_q  <= a_mag;
                  rs_q      <= rs_data;
                  cnt_q     <= '0;
                  state_q   <= ST_RUN;
               end else begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end
            ST_RUN: begin
               acc_q    <= acc_step;
               mplier_q <= mplier_step;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_q <= ST_FIX;
            end
            ST_FIX: begin
               if (is_div_q) begin
                  if (divisor_zero) begin
                     hi_q <= rs_q;
                     lo_q <= '1;
                     dz_q <= 1'b1;
                  end else begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver queues expected HI/LO results and
// done times, and a negedge monitor checks every done pulse against the queue.
module tb_mul_div_unit;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   mul_div_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0) begin
         if (done && busy) chk("done_busy_overlap", 64'(busy), 64'd0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("hi", 64'(hi), 64'(e.hi));
               chk("lo", 64'(lo), 64'(e.lo));
               chk("div_zero", 64'(div_zero), 64'(e.dz));
               chk("latency", 64'(cyc), 64'(e.due));
            end
         end else if (div_zero) begin
            chk("div_zero_without_done", 64'(div_zero), 64'd0);
         end
      end
   end

   // Called at a negedge; start is sampled on the following posedge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input bit expect_it);
      exp_t e;
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      if (expect_it) begin
         e.hi  = ehi;
         e.lo  = elo;
         e.dz  = edz;
         e.due = cyc + 34;
         sb.push_back(e);
      end
      @(negedge clk);
      start   = 1'b0;
      op      = 2'($urandom);
      rs_data = $urandom;
      rt_data = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
      issue(o, a, b, ehi, elo, edz, 1'b1);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "bench timed out");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);

      run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run(OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);
      run(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      run(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      run(OP_DIVU,  32'd20,       32'd8,        32'd4,        32'd2,        1'b0);
      run(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
      run(OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
      run(OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
      run(OP_DIVU,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
      run(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

      // Second start mid-run with different operands must be ignored.
      issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Back-to-back: new start in the done cycle is accepted.
      issue(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      issue(OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 1'b1);
      wait_idle();

      // Reset in the middle of a run aborts it without a done pulse.
      issue(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      repeat (40) @(negedge clk);

      // MTHI/MTLO in idle, then writes dropped alongside start and while busy.
      hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi", 64'(hi), 64'h1234);
      lo_we = 1'b1; wdata = 32'h5678;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo", 64'(lo), 64'h5678);
      hi_we = 1'b1; wdata = 32'hBAD0BAD0;
      issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      hi_we = 1'b0;
      chk("start_beats_mthi", 64'(hi), 64'h1234);
      lo_we = 1'b1; wdata = 32'hDEADBEEF;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo_while_busy", 64'(lo), 64'h5678);
      chk("hi_held_while_busy", 64'(hi), 64'h1234);
      wait_idle();

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
